// File: rtl/hook_cable_controller.sv
// Hook/cable sequencer: swings the launch direction while idle, then drives extend/retract
// speed commands for the position integrator and reports a score when a loaded hook docks.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | hook parked, direction swings ping-pong on frame ticks
//  S_EXTEND  | hook travels out along the frozen direction
//  S_GRAB    | one cycle, object attached, grab pulse asserted
//  S_RETRACT | hook travels home, speed reduced by carried weight
//  S_DOCK    | one cycle, hook home, score pulse if loaded
module hook_cable_controller #(
    parameter int SPEED_UNIT        = 10,
    parameter int SWING_FRAMES      = 8,
    parameter int MAX_EXTEND_FRAMES = 120
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        launch_key,
    input  logic        hit_object,
    input  logic        hit_border,
    input  logic [1:0]  object_weight,
    input  logic [7:0]  object_value,
    input  logic        hook_at_home,
    output logic [11:0] Xspeed_cmd,
    output logic [11:0] Yspeed_cmd,
    output logic [2:0]  dir_index,
    output logic        busy,
    output logic        grab_pulse,
    output logic        score_valid,
    output logic [7:0]  score_value
);

    localparam int SW = $clog2(SWING_FRAMES + 1);
    localparam int FW = $clog2(MAX_EXTEND_FRAMES + 1);
    localparam logic signed [11:0] SPD1 = 12'(SPEED_UNIT);
    localparam logic signed [11:0] SPD2 = 12'(2 * SPEED_UNIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXTEND,
        S_GRAB,
        S_RETRACT,
        S_DOCK
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         dir_q, dir_d;
    logic               swing_up_q, swing_up_d;
    logic [SW-1:0]      swing_cnt_q, swing_cnt_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               ret_seen_q, ret_seen_d;
    logic               loaded_q, loaded_d;
    logic [1:0]         weight_q, weight_d;
    logic [7:0]         value_q, value_d;
    logic signed [11:0] xspeed_q, xspeed_d;
    logic signed [11:0] yspeed_q, yspeed_d;
    logic               busy_q, busy_d;
    logic               grab_q, grab_d;
    logic               score_valid_q, score_valid_d;
    logic [7:0]         score_value_q, score_value_d;

    logic signed [11:0] ext_x, ext_y;
    logic [1:0]         eff_weight;
    logic               timeout;

    // Shift the magnitude (truncate toward zero), reverse the sign, never let a moving axis stall.
    function automatic logic signed [11:0] retract_comp(input logic signed [11:0] e,
                                                         input logic [1:0] w);
        logic [11:0] mag;
        logic [11:0] sh;
        mag = e[11] ? 12'(-e) : 12'(e);
        sh  = mag >> w;
        if (e == 12'sd0) begin
            return 12'sd0;
        end
        if (sh == 12'd0) begin
            sh = 12'd1;
        end
        return e[11] ? sh : -sh;
    endfunction

    always_comb begin
        ext_x = 12'sd0;
        ext_y = 12'sd0;
        case (dir_q)
            3'd0: begin ext_x = -SPD2; ext_y = SPD1; end
            3'd1: begin ext_x = -SPD1; ext_y = SPD2; end
            3'd2: begin ext_x = 12'sd0; ext_y = SPD2; end
            3'd3: begin ext_x = SPD1;  ext_y = SPD2; end
            3'd4: begin ext_x = SPD2;  ext_y = SPD1; end
            default: begin ext_x = 12'sd0; ext_y = 12'sd0; end
        endcase
    end

    assign eff_weight = loaded_q ? weight_q : 2'd0;
    assign timeout    = startOfFrame && (frame_cnt_q == FW'(MAX_EXTEND_FRAMES - 1));

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        swing_up_d    = swing_up_q;
        swing_cnt_d   = swing_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        ret_seen_d    = ret_seen_q;
        loaded_d      = loaded_q;
        weight_d      = weight_q;
        value_d       = value_q;
        xspeed_d      = xspeed_q;
        yspeed_d      = yspeed_q;
        grab_d        = 1'b0;
        score_valid_d = 1'b0;
        score_value_d = score_value_q;

        case (state_q)
            S_IDLE: begin
                xspeed_d = 12'sd0;
                yspeed_d = 12'sd0;
                if (launch_key) begin
                    state_d     = S_EXTEND;
                    frame_cnt_d = startOfFrame ? FW'(1) : FW'(0);
                    loaded_d    = 1'b0;
                    xspeed_d    = ext_x;
                    yspeed_d    = ext_y;
                end else if (startOfFrame) begin
                    if (swing_cnt_q == SW'(SWING_FRAMES - 1)) begin
                        swing_cnt_d = '0;
                        if (swing_up_q) begin
                            if (dir_q == 3'd4) begin
                                dir_d      = 3'd3;
                                swing_up_d = 1'b0;
                            end else begin
                                dir_d = dir_q + 3'd1;
                            end
                        end else begin
                            if (dir_q == 3'd0) begin
                                dir_d      = 3'd1;
                                swing_up_d = 1'b1;
                            end else begin
                                dir_d = dir_q - 3'd1;
                            end
                        end
                    end else begin
                        swing_cnt_d = swing_cnt_q + SW'(1);
                    end
                end
            end
            S_EXTEND: begin
                if (hit_object) begin
                    state_d  = S_GRAB;
                    grab_d   = 1'b1;
                    loaded_d = 1'b1;
                    weight_d = object_weight;
                    value_d  = object_value;
                end else if (hit_border || timeout) begin
                    state_d    = S_RETRACT;
                    ret_seen_d = startOfFrame;
                    xspeed_d   = retract_comp(ext_x, 2'd0);
                    yspeed_d   = retract_comp(ext_y, 2'd0);
                end else if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                end
            end
            S_GRAB: begin
                state_d    = S_RETRACT;
                ret_seen_d = startOfFrame;
                xspeed_d   = retract_comp(ext_x, eff_weight);
                yspeed_d   = retract_comp(ext_y, eff_weight);
            end
            S_RETRACT: begin
                if (ret_seen_q && hook_at_home) begin
                    state_d  = S_DOCK;
                    xspeed_d = 12'sd0;
                    yspeed_d = 12'sd0;
                    if (loaded_q) begin
                        score_valid_d = 1'b1;
                        score_value_d = value_q;
                    end
                end else if (startOfFrame) begin
                    ret_seen_d = 1'b1;
                end
            end
            S_DOCK: begin
                state_d  = S_IDLE;
                loaded_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= S_IDLE;
            dir_q         <= 3'd2;
            swing_up_q    <= 1'b1;
            swing_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            ret_seen_q    <= 1'b0;
            loaded_q      <= 1'b0;
            weight_q      <= 2'd0;
            value_q       <= 8'd0;
            xspeed_q      <= 12'sd0;
            yspeed_q      <= 12'sd0;
            busy_q        <= 1'b0;
            grab_q        <= 1'b0;
            score_valid_q <= 1'b0;
            score_value_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            swing_up_q    <= swing_up_d;
            swing_cnt_q   <= swing_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            ret_seen_q    <= ret_seen_d;
            loaded_q      <= loaded_d;
            weight_q      <= weight_d;
            value_q       <= value_d;
            xspeed_q      <= xspeed_d;
            yspeed_q      <= yspeed_d;
            busy_q        <= busy_d;
            grab_q        <= grab_d;
            score_valid_q <= score_valid_d;
            score_value_q <= score_value_d;
        end
    end

    assign Xspeed_cmd  = xspeed_q;
    assign Yspeed_cmd  = yspeed_q;
    assign dir_index   = dir_q;
    assign busy        = busy_q;
    assign grab_pulse  = grab_q;
    assign score_valid = score_valid_q;
    assign score_value = score_value_q;

endmodule
